stage_arbiter: RTL and testbench

STAGE_ARBITER -- requirements
Module: stage_arbiter

---
 rtl/stage_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/stage_arbiter.sv | 142 ++++++++++++++
 tb/tb_stage_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stage_arb_pkg.sv
// Shared state encoding, default configuration constants and pointer helper
// for the stage arbiter.
package stage_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Advance a requester index by one, wrapping at n.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v, input int n);
    if (int'(v) >= n - 1) begin
      return 2'd0;
    end else begin
      return v + 2'd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req starting at ptr,
// searching upward with wrap.
module rr_pick
  import stage_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       idx,
  output logic             valid
);

  logic [2:0] sum;
  logic [2:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    sum   = 3'd0;
    cand  = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum  = {1'b0, ptr} + 3'(k);
      cand = (sum >= 3'(N_REQ)) ? (sum - 3'(N_REQ)) : sum;
      if (req[cand[1:0]]) begin
        idx   = cand[1:0];
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/stage_arbiter.sv
// Round-robin arbiter feeding one downstream pipeline stage (IDLE/OFFER/RELEASE).
// Optional OFFER timeout compiled in with STAGE_ARB_TIMEOUT_EN.
module stage_arbiter
  import stage_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_dor,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    DIR,
  output logic [DATA_W-1:0]       data_out,
  input  logic                    ack_in,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  arb_state_t        state, state_n;
  logic [1:0]        ptr, ptr_n, gid_n, pick_idx;
  logic              pick_valid, dir_n, busy_n, err_n;
  logic [DATA_W-1:0] data_n;
  logic [N_REQ-1:0]  ack_n;

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("stage_arbiter: parameter out of range");
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req_dor),
    .ptr  (ptr),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

`ifdef STAGE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tmo_hit;

  assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // OFFER cycle counter; cnt holds the number of OFFER cycles already elapsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      DIR         <= 1'b0;
      data_out    <= '0;
      req_ack     <= '0;
      grant_id    <= 2'd0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      DIR         <= dir_n;
      data_out    <= data_n;
      req_ack     <= ack_n;
      grant_id    <= gid_n;
      busy        <= busy_n;
      err_timeout <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dir_n   = DIR;
    data_n  = data_out;
    ack_n   = '0;
    gid_n   = grant_id;
    err_n   = err_timeout;
`ifdef STAGE_ARB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          data_n  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          gid_n   = pick_idx;
          dir_n   = 1'b1;
          state_n = OFFER;
`ifdef STAGE_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end else begin
          dir_n = 1'b0;
        end
      end
      OFFER: begin
        // An accept on the terminal-count cycle wins over the timeout.
        if (ack_in) begin
          dir_n   = 1'b0;
          data_n  = '0;
          ack_n   = N_REQ'(1'b1) << grant_id;
          ptr_n   = wrap_inc(grant_id, N_REQ);
          state_n = RELEASE;
        end else begin
`ifdef STAGE_ARB_TIMEOUT_EN
          if (tmo_hit) begin
            dir_n   = 1'b0;
            data_n  = '0;
            err_n   = 1'b1;
            ptr_n   = wrap_inc(grant_id, N_REQ);
            state_n = RELEASE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
`else
          state_n = OFFER;
`endif
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        dir_n   = 1'b0;
        data_n  = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_stage_arbiter.sv
// Directed bench for stage_arbiter; timeout checks run when STAGE_ARB_TIMEOUT_EN is defined.
module tb_stage_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_dor;
  logic [31:0] req_data;
  logic [3:0] req_ack;
  logic       DIR;
  logic [7:0] data_out;
  logic       ack_in;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  int errors = 0;
  int checks = 0;
  logic [7:0] word [4];
  logic [1:0] rr_order [5];

  stage_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_dor    (req_dor),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .DIR        (DIR),
    .data_out   (data_out),
    .ack_in     (ack_in),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    word[0] = 8'h05; word[1] = 8'h11; word[2] = 8'h12; word[3] = 8'h13;
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2;
    rr_order[3] = 2'd3; rr_order[4] = 2'd0;
    req_data = {word[3], word[2], word[1], word[0]};
    reset   = 1'b0;
    req_dor = 4'b0001;
    ack_in  = 1'b0;

    // Basic grant/accept out of reset
    step(); step();
    chk("rst_dir",  32'(DIR), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_gid",  32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack",  32'(req_ack), 32'd0);
    chk("rst_err",  32'(err_timeout), 32'd0);
    reset = 1'b1;
    step();
    chk("t1_dir",  32'(DIR), 32'd1);
    chk("t1_data", 32'(data_out), 32'h05);
    chk("t1_gid",  32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    ack_in = 1'b1;
    step();
    ack_in  = 1'b0;
    req_dor = 4'b0000;
    chk("t1_ack",      32'(req_ack), 32'h1);
    chk("t1_dir_drop", 32'(DIR), 32'd0);
    chk("t1_data_clr", 32'(data_out), 32'd0);
    chk("t1_rel_busy", 32'(busy), 32'd1);
    step();
    chk("t1_ack_1cyc", 32'(req_ack), 32'h0);
    chk("t1_idle",     32'(busy), 32'd0);

    // Round robin with all requesters active, starting from ptr=0
    reset = 1'b0;
    #1;
    reset   = 1'b1;
    req_dor = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_dir",  32'(DIR), 32'd1);
      chk("rr_gid",  32'(grant_id), 32'(rr_order[g]));
      chk("rr_data", 32'(data_out), 32'(word[rr_order[g]]));
      step();
      chk("rr_hold", 32'(grant_id), 32'(rr_order[g]));
      ack_in = 1'b1;
      step();
      ack_in = 1'b0;
      chk("rr_ack", 32'(req_ack), 32'(4'b0001 << rr_order[g]));
      chk("rr_rel_dir", 32'(DIR), 32'd0);
      step();
      chk("rr_ack_off", 32'(req_ack), 32'h0);
    end

    // Single requester 2 drops DOR after its acknowledge
    req_dor = 4'b0100;
    step();
    chk("s2_gid",  32'(grant_id), 32'd2);
    chk("s2_data", 32'(data_out), 32'h12);
    ack_in = 1'b1;
    step();
    ack_in  = 1'b0;
    req_dor = 4'b0000;
    chk("s2_ack", 32'(req_ack), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s2_no_regrant", 32'(DIR), 32'd0);
    end

    // Asynchronous reset in the middle of OFFER
    req_dor = 4'b0010;
    step();
    chk("mr_gid", 32'(grant_id), 32'd1);
    chk("mr_dir", 32'(DIR), 32'd1);
    req_dor = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    chk("mr_dir_clr",  32'(DIR), 32'd0);
    chk("mr_data_clr", 32'(data_out), 32'd0);
    chk("mr_ack_clr",  32'(req_ack), 32'h0);
    chk("mr_gid_clr",  32'(grant_id), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("mr_ptr0_gid", 32'(grant_id), 32'd0);
    chk("mr_resume",   32'(DIR), 32'd1);

`ifdef STAGE_ARB_TIMEOUT_EN
    // 16 OFFER cycles without accept: timeout, no acknowledge
    for (int i = 0; i < 15; i++) step();
    chk("to_dir_before", 32'(DIR), 32'd1);
    chk("to_err_before", 32'(err_timeout), 32'd0);
    step();
    chk("to_dir_drop", 32'(DIR), 32'd0);
    chk("to_err_set",  32'(err_timeout), 32'd1);
    chk("to_no_ack",   32'(req_ack), 32'h0);
    chk("to_data_clr", 32'(data_out), 32'd0);
    step();
    chk("to_no_ack2", 32'(req_ack), 32'h0);
    step();
    chk("to_ptr_adv", 32'(grant_id), 32'd1);
    chk("to_sticky",  32'(err_timeout), 32'd1);
    // Accept on the terminal-count cycle after a fresh reset
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    chk("tc_gid", 32'(grant_id), 32'd0);
    for (int i = 0; i < 15; i++) step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    chk("tc_ack", 32'(req_ack), 32'h1);
    chk("tc_err", 32'(err_timeout), 32'd0);
    chk("tc_dir", 32'(DIR), 32'd0);
`else
    // Without the timeout, OFFER is held indefinitely
    for (int i = 0; i < 20; i++) step();
    chk("nt_dir_hold", 32'(DIR), 32'd1);
    chk("nt_gid_hold", 32'(grant_id), 32'd0);
    chk("nt_err",      32'(err_timeout), 32'd0);
    chk("nt_no_ack",   32'(req_ack), 32'h0);
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    chk("nt_ack", 32'(req_ack), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
